// File: rtl/usb_tx_encoder_if.sv
// Byte-side handshake, bit-timer strobe and line/status outputs of the
// USB transmit encoder, bundled so the packet controller and the encoder
// share one connection.
interface usb_tx_encoder_if;
  logic       shift_enable;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       pause;
  logic       busy;
  logic       eop_done;
  logic       underrun;
  logic       dplus_out;
  logic       dminus_out;

  // Upstream side: packet controller plus bit timer.
  modport master (
    output shift_enable, tx_valid, tx_data, tx_last,
    input  tx_ready, pause, busy, eop_done, underrun, dplus_out, dminus_out
  );

  // Encoder side.
  modport slave (
    input  shift_enable, tx_valid, tx_data, tx_last,
    output tx_ready, pause, busy, eop_done, underrun, dplus_out, dminus_out
  );
endinterface

// File: rtl/usb_tx_encoder.sv
// USB transmit serial back end: one-byte holding buffer, LSB-first shifter,
// bit stuffing after six consecutive ones, NRZI line coding and EOP
// generation (SE0, SE0, J). Line outputs are registered and change only on
// edges that sample shift_enable high.
module usb_tx_encoder (
  input  logic              clk,
  input  logic              rst,
  usb_tx_encoder_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    STUFF     = 3'd2,
    EOP_SE0_1 = 3'd3,
    EOP_SE0_2 = 3'd4,
    EOP_J     = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  // Holding buffer.
  logic [7:0] r_buf_data;
  logic       r_buf_last;
  logic       r_buf_full;

  // Shifter; r_bit_idx is the index of the data bit currently on the line.
  logic [7:0] r_sh_data;
  logic       r_sh_last;
  logic [2:0] r_bit_idx;
  logic [2:0] r_ones_cnt;

  logic       r_dp;
  logic       r_dm;
  logic       r_eop_done;
  logic       r_underrun;

  logic [7:0] w_sh_data_next;
  logic       w_sh_last_next;
  logic [2:0] w_bit_idx_next;
  logic [2:0] w_ones_cnt_next;
  logic       w_dp_next;
  logic       w_dm_next;
  logic       w_eop_done_next;
  logic       w_underrun_next;
  logic       w_accept;
  logic       w_move;
  logic       w_load;
  logic       w_send;
  logic       w_bit;
  logic [2:0] w_bit_idx_inc;

  assign w_accept      = bus.tx_valid & ~r_buf_full;
  assign w_bit_idx_inc = r_bit_idx + 3'd1;

  // State register; reset puts the line back to idle J at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and datapath decisions, evaluated only on bit-time strobes.
  always_comb begin
    w_state_next    = r_state;
    w_sh_data_next  = r_sh_data;
    w_sh_last_next  = r_sh_last;
    w_bit_idx_next  = r_bit_idx;
    w_ones_cnt_next = r_ones_cnt;
    w_dp_next       = r_dp;
    w_dm_next       = r_dm;
    w_eop_done_next = 1'b0;
    w_underrun_next = 1'b0;
    w_move          = 1'b0;
    w_load          = 1'b0;
    w_send          = 1'b0;
    w_bit           = 1'b0;

    if (bus.shift_enable) begin
      case (r_state)
        IDLE: begin
          if (r_buf_full) w_load = 1'b1;
        end
        DATA, STUFF: begin
          if (r_state == DATA && r_ones_cnt == 3'd6) begin
            // Stuffed zero: toggle, bit index stays put.
            w_state_next    = STUFF;
            w_dp_next       = ~r_dp;
            w_dm_next       = ~r_dm;
            w_ones_cnt_next = 3'd0;
          end else if (r_bit_idx == 3'd7) begin
            // Byte boundary: chain, end the packet, or abort it.
            if (!r_sh_last && r_buf_full) begin
              w_load = 1'b1;
            end else begin
              w_underrun_next = ~r_sh_last;
              w_state_next    = EOP_SE0_1;
              w_dp_next       = 1'b0;
              w_dm_next       = 1'b0;
            end
          end else begin
            w_state_next   = DATA;
            w_bit_idx_next = w_bit_idx_inc;
            w_send         = 1'b1;
            w_bit          = r_sh_data[w_bit_idx_inc];
          end
        end
        EOP_SE0_1: begin
          w_state_next = EOP_SE0_2;
        end
        EOP_SE0_2: begin
          w_state_next = EOP_J;
          w_dp_next    = 1'b1;
          w_dm_next    = 1'b0;
        end
        EOP_J: begin
          w_state_next    = IDLE;
          w_eop_done_next = 1'b1;
          w_ones_cnt_next = 3'd0;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase

      // Pull the buffered byte into the shifter and put its bit 0 out now.
      if (w_load) begin
        w_move         = 1'b1;
        w_state_next   = DATA;
        w_sh_data_next = r_buf_data;
        w_sh_last_next = r_buf_last;
        w_bit_idx_next = 3'd0;
        w_send         = 1'b1;
        w_bit          = r_buf_data[0];
      end

      // NRZI: a zero toggles J/K, a one holds and extends the run of ones.
      if (w_send) begin
        if (w_bit) begin
          w_ones_cnt_next = r_ones_cnt + 3'd1;
        end else begin
          w_ones_cnt_next = 3'd0;
          w_dp_next       = ~r_dp;
          w_dm_next       = ~r_dm;
        end
      end
    end
  end

  // Datapath, holding buffer and registered line/pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_data <= 8'h00;
      r_buf_last <= 1'b0;
      r_buf_full <= 1'b0;
      r_sh_data  <= 8'h00;
      r_sh_last  <= 1'b0;
      r_bit_idx  <= 3'd0;
      r_ones_cnt <= 3'd0;
      r_dp       <= 1'b1;
      r_dm       <= 1'b0;
      r_eop_done <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_buf_data <= bus.tx_data;
        r_buf_last <= bus.tx_last;
      end
      r_buf_full <= w_accept | (r_buf_full & ~w_move);
      r_sh_data  <= w_sh_data_next;
      r_sh_last  <= w_sh_last_next;
      r_bit_idx  <= w_bit_idx_next;
      r_ones_cnt <= w_ones_cnt_next;
      r_dp       <= w_dp_next;
      r_dm       <= w_dm_next;
      r_eop_done <= w_eop_done_next;
      r_underrun <= w_underrun_next;
    end
  end

  assign bus.tx_ready   = ~r_buf_full;
  assign bus.pause      = (r_state == STUFF);
  assign bus.busy       = (r_state != IDLE);
  assign bus.eop_done   = r_eop_done;
  assign bus.underrun   = r_underrun;
  assign bus.dplus_out  = r_dp;
  assign bus.dminus_out = r_dm;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: every bit-time compares the line
// state and status flags with a hand-derived expected sequence.
module tb_usb_tx_encoder;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n = 0;

  // Line states {D+, D-}.
  localparam logic [1:0] J  = 2'b10;
  localparam logic [1:0] K  = 2'b01;
  localparam logic [1:0] S0 = 2'b00;
  // Flags {pause, busy, eop_done, underrun}.
  localparam logic [3:0] IDL = 4'b0000;
  localparam logic [3:0] D   = 4'b0100;
  localparam logic [3:0] P   = 4'b1100;
  localparam logic [3:0] E   = 4'b0010;
  localparam logic [3:0] U   = 4'b0101;

  usb_tx_encoder_if bus ();

  usb_tx_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One bit-time: strobe (or just a clock when shift_enable is held high),
  // then compare line and flags sampled on the following falling edge.
  task automatic step(input logic [1:0] el, input logic [3:0] fl, input bit cont, input string tag);
    logic [7:0] obs;
    if (!cont) begin
      @(negedge clk) bus.shift_enable = 1'b1;
      @(negedge clk) bus.shift_enable = 1'b0;
    end else begin
      @(negedge clk);
    end
    n++;
    obs = {2'b00, bus.dplus_out, bus.dminus_out, bus.pause, bus.busy, bus.eop_done, bus.underrun};
    $display("bit %0d %s: line=%b%b pause=%b busy=%b eop_done=%b underrun=%b",
             n, tag, bus.dplus_out, bus.dminus_out, bus.pause, bus.busy, bus.eop_done, bus.underrun);
    chk($sformatf("%s_bit%0d", tag, n), obs, {2'b00, el, fl});
    if (!cont) begin
      @(negedge clk);
      chk($sformatf("%s_pulse_clear%0d", tag, n), {6'b0, bus.eop_done, bus.underrun}, 8'h00);
    end
  endtask

  task automatic load(input logic [7:0] d, input logic l, input string tag);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    bus.tx_last  = l;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    $display("load %s: data=%h last=%b", tag, d, l);
    chk({tag, "_ready_fall"}, {7'b0, bus.tx_ready}, 8'h00);
  endtask

  task automatic eop(input bit cont, input string tag);
    step(S0, D, cont, tag);
    step(S0, D, cont, tag);
    step(J,  D, cont, tag);
    step(J,  E, cont, tag);
  endtask

  initial begin
    rst = 1'b1;
    bus.shift_enable = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {1'b0, bus.dplus_out, bus.dminus_out, bus.tx_ready, bus.pause,
        bus.busy, bus.eop_done, bus.underrun}, 8'b0101_0000);
    rst = 1'b0;

    // 0x00 last: eight toggles then EOP.
    load(8'h00, 1'b1, "b00");
    step(K, D, 0, "b00"); step(J, D, 0, "b00"); step(K, D, 0, "b00"); step(J, D, 0, "b00");
    step(K, D, 0, "b00"); step(J, D, 0, "b00"); step(K, D, 0, "b00"); step(J, D, 0, "b00");
    eop(0, "b00");

    // 0xFF last: six ones hold J, stuffed K, two more ones hold K.
    load(8'hFF, 1'b1, "bff");
    step(J, D, 0, "bff"); step(J, D, 0, "bff"); step(J, D, 0, "bff");
    step(J, D, 0, "bff"); step(J, D, 0, "bff"); step(J, D, 0, "bff");
    step(K, P, 0, "bff"); step(K, D, 0, "bff"); step(K, D, 0, "bff");
    eop(0, "bff");

    // 0x3F then 0x80 last: stuff after bit 5 of the first byte, seamless reload.
    load(8'h3F, 1'b0, "b3f");
    step(J, D, 0, "b3f");
    chk("b3f_ready_rise", {7'b0, bus.tx_ready}, 8'h01);
    load(8'h80, 1'b1, "b80");
    step(J, D, 0, "b3f"); step(J, D, 0, "b3f"); step(J, D, 0, "b3f");
    step(J, D, 0, "b3f"); step(J, D, 0, "b3f");
    step(K, P, 0, "b3f"); step(J, D, 0, "b3f"); step(K, D, 0, "b3f");
    step(J, D, 0, "b80");
    chk("b80_ready_rise", {7'b0, bus.tx_ready}, 8'h01);
    step(K, D, 0, "b80"); step(J, D, 0, "b80"); step(K, D, 0, "b80");
    step(J, D, 0, "b80"); step(K, D, 0, "b80"); step(J, D, 0, "b80"); step(J, D, 0, "b80");
    eop(0, "b80");

    // 0xF0 then 0x03 last: run of ones crosses the byte boundary.
    load(8'hF0, 1'b0, "bf0");
    step(K, D, 0, "bf0");
    load(8'h03, 1'b1, "b03");
    step(J, D, 0, "bf0"); step(K, D, 0, "bf0"); step(J, D, 0, "bf0");
    step(J, D, 0, "bf0"); step(J, D, 0, "bf0"); step(J, D, 0, "bf0"); step(J, D, 0, "bf0");
    step(J, D, 0, "b03"); step(J, D, 0, "b03"); step(K, P, 0, "b03");
    step(J, D, 0, "b03"); step(K, D, 0, "b03"); step(J, D, 0, "b03");
    step(K, D, 0, "b03"); step(J, D, 0, "b03"); step(K, D, 0, "b03");
    eop(0, "b03");

    // 0x55 not last with nothing queued: underrun aborts into EOP.
    load(8'h55, 1'b0, "b55");
    step(J, D, 0, "b55"); step(K, D, 0, "b55"); step(K, D, 0, "b55"); step(J, D, 0, "b55");
    step(J, D, 0, "b55"); step(K, D, 0, "b55"); step(K, D, 0, "b55"); step(J, D, 0, "b55");
    step(S0, U, 0, "b55");
    step(S0, D, 0, "b55"); step(J, D, 0, "b55"); step(J, E, 0, "b55");

    // Reset after bit 3 of 0x08 with a byte queued.
    load(8'h08, 1'b1, "b08");
    step(K, D, 0, "b08"); step(J, D, 0, "b08"); step(K, D, 0, "b08"); step(K, D, 0, "b08");
    load(8'hAA, 1'b1, "baa");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async", {4'b0, bus.dplus_out, bus.dminus_out, bus.tx_ready, bus.busy}, 8'b0000_1010);
    @(negedge clk) rst = 1'b0;
    step(J, IDL, 0, "rst_discard");
    load(8'h01, 1'b1, "b01");
    step(J, D, 0, "b01"); step(K, D, 0, "b01"); step(J, D, 0, "b01"); step(K, D, 0, "b01");
    step(J, D, 0, "b01"); step(K, D, 0, "b01"); step(J, D, 0, "b01"); step(K, D, 0, "b01");
    eop(0, "b01");

    // 0xFE last with shift_enable held high: one bit per clock.
    load(8'hFE, 1'b1, "bfe");
    bus.shift_enable = 1'b1;
    step(K, D, 1, "bfe");
    step(K, D, 1, "bfe"); step(K, D, 1, "bfe"); step(K, D, 1, "bfe");
    step(K, D, 1, "bfe"); step(K, D, 1, "bfe"); step(K, D, 1, "bfe");
    step(J, P, 1, "bfe"); step(J, D, 1, "bfe");
    eop(1, "bfe");
    step(J, IDL, 1, "bfe_idle");
    bus.shift_enable = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
